// File: rtl/vga_dxdy_up.sv
// Display-to-source coordinate mapper for a 9/16 upscaler: accumulates source
// position per pixel/line, emits integer+fraction coordinates and drives line prefetch.
module vga_dxdy_up #(
    parameter int DST_W = 1280,
    parameter int DST_H = 960,
    parameter int SRC_W = 720,
    parameter int SRC_H = 540
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vga_vs,
    input  logic       vga_de,
    input  logic       vga_hs_end,
    input  logic       line_ack,
    output logic [9:0] src_x,
    output logic [9:0] src_y,
    output logic [3:0] vga_dx,
    output logic [3:0] vga_dy,
    output logic [7:0] vga_dxy,
    output logic       xy_vld,
    output logic       line_req,
    output logic [9:0] line_row,
    output logic       err_underflow
);

    // Per-step increment in 1/16 source units (9 for 720/1280 and 540/960)
    localparam int unsigned STEP_X = (SRC_W * 16) / DST_W;
    localparam int unsigned STEP_Y = (SRC_H * 16) / DST_H;
    localparam logic [13:0] INC_X  = 14'(STEP_X);
    localparam logic [13:0] INC_Y  = 14'(STEP_Y);
    localparam logic [9:0]  X_LAST = 10'(SRC_W - 1);
    localparam logic [9:0]  Y_LAST = 10'(SRC_H - 1);
    localparam logic [10:0] ROW_END = 11'(SRC_H);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE0 = 3'd1,
        PRE1 = 3'd2,
        RUN  = 3'd3,
        REQ  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [13:0] acc_x, acc_y, acc_y_nxt;
    logic [9:0]  cur_x, cur_y, new_y;
    logic [3:0]  cur_dx, cur_dy;
    logic [10:0] fetch_row;
    logic        fetch_ok;

    logic       s1_vld;
    logic [9:0] s1_x, s1_y;
    logic [3:0] s1_dx, s1_dy;

    logic       req_nxt;
    logic [9:0] row_nxt;

    assign acc_y_nxt = acc_y + INC_Y;
    assign cur_x     = acc_x[13:4];
    assign cur_y     = acc_y[13:4];
    assign new_y     = acc_y_nxt[13:4];
    assign cur_dx    = (cur_x == X_LAST) ? '0 : acc_x[3:0];
    assign cur_dy    = (cur_y == Y_LAST) ? '0 : acc_y[3:0];
    assign fetch_row = {1'b0, new_y} + 11'd1;
    assign fetch_ok  = (new_y > cur_y) && (fetch_row < ROW_END);

    // Accumulators; vga_vs dominates a coincident vga_hs_end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x <= '0;
            acc_y <= '0;
        end else begin
            if (vga_vs || vga_hs_end) acc_x <= '0;
            else if (vga_de)          acc_x <= acc_x + INC_X;
            if (vga_vs)               acc_y <= '0;
            else if (vga_hs_end)      acc_y <= acc_y_nxt;
        end
    end

    // Two-stage output pipeline; independent of vga_vs so in-flight pixels drain intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_dx   <= '0;
            s1_dy   <= '0;
            xy_vld  <= 1'b0;
            src_x   <= '0;
            src_y   <= '0;
            vga_dx  <= '0;
            vga_dy  <= '0;
            vga_dxy <= '0;
        end else begin
            s1_vld <= vga_de;
            if (vga_de) begin
                s1_x  <= cur_x;
                s1_y  <= cur_y;
                s1_dx <= cur_dx;
                s1_dy <= cur_dy;
            end
            xy_vld <= s1_vld;
            if (s1_vld) begin
                src_x   <= s1_x;
                src_y   <= s1_y;
                vga_dx  <= s1_dx;
                vga_dy  <= s1_dy;
                vga_dxy <= {4'b0, s1_dx} * {4'b0, s1_dy};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            line_req      <= 1'b0;
            line_row      <= '0;
            err_underflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            line_req <= req_nxt;
            line_row <= row_nxt;
            if (vga_vs)
                err_underflow <= 1'b0;
            else if (vga_de && (state == PRE0 || state == PRE1 || state == REQ))
                err_underflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (vga_vs) begin
            state_nxt = PRE0;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                PRE0: if (line_req && line_ack) state_nxt = PRE1;
                PRE1: if (line_req && line_ack) state_nxt = RUN;
                RUN:  if (vga_hs_end && fetch_ok) state_nxt = REQ;
                REQ:  if (line_req && line_ack) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Request drops for at least one cycle after every ack, so line_row only changes while low
    always_comb begin
        req_nxt = 1'b0;
        row_nxt = line_row;
        if (!vga_vs && !(line_req && line_ack)) begin
            case (state_nxt)
                PRE0: begin
                    req_nxt = 1'b1;
                    row_nxt = 10'd0;
                end
                PRE1: begin
                    req_nxt = 1'b1;
                    row_nxt = 10'd1;
                end
                REQ: begin
                    req_nxt = 1'b1;
                    if (state == RUN) row_nxt = fetch_row[9:0];
                end
                default: req_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_dxdy_up.sv
// Directed bench for vga_dxdy_up: coordinates, clamps, line prefetch handshake,
// underflow flag, vs abort and asynchronous reset.
module tb_vga_dxdy_up;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vga_vs = 1'b0;
    logic vga_de = 1'b0;
    logic vga_hs_end = 1'b0;
    logic line_ack = 1'b0;
    logic [9:0] src_x, src_y, line_row;
    logic [3:0] vga_dx, vga_dy;
    logic [7:0] vga_dxy;
    logic xy_vld, line_req, err_underflow;

    int checks = 0;
    int failures = 0;

    logic [9:0] cx [1280];
    logic [9:0] cy [1280];
    logic [3:0] cdx [1280];
    logic [3:0] cdy [1280];
    logic [7:0] cdxy [1280];
    int cap_n = 0;

    vga_dxdy_up #(.DST_W(1280), .DST_H(960), .SRC_W(720), .SRC_H(540)) dut (
        .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_hs_end(vga_hs_end), .line_ack(line_ack),
        .src_x(src_x), .src_y(src_y), .vga_dx(vga_dx), .vga_dy(vga_dy),
        .vga_dxy(vga_dxy), .xy_vld(xy_vld), .line_req(line_req),
        .line_row(line_row), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Record each valid output pixel of the current line
    always @(negedge clk) begin
        if (vga_hs_end || vga_vs) begin
            cap_n = 0;
        end else if (xy_vld && cap_n < 1280) begin
            cx[cap_n]   = src_x;
            cy[cap_n]   = src_y;
            cdx[cap_n]  = vga_dx;
            cdy[cap_n]  = vga_dy;
            cdxy[cap_n] = vga_dxy;
            cap_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_line(input int n);
        vga_de = 1'b1;
        steps(n);
        vga_de = 1'b0;
        steps(3);
    endtask

    task automatic end_line();
        vga_hs_end = 1'b1;
        step();
        vga_hs_end = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_src_x"}, 32'(src_x), 0);
        chk({tag, "_src_y"}, 32'(src_y), 0);
        chk({tag, "_dx"}, 32'(vga_dx), 0);
        chk({tag, "_dy"}, 32'(vga_dy), 0);
        chk({tag, "_dxy"}, 32'(vga_dxy), 0);
        chk({tag, "_vld"}, 32'(xy_vld), 0);
        chk({tag, "_req"}, 32'(line_req), 0);
        chk({tag, "_row"}, 32'(line_row), 0);
        chk({tag, "_err"}, 32'(err_underflow), 0);
        chk({tag, "_state"}, 32'(dut.state), 0);
        chk({tag, "_acc_x"}, 32'(dut.acc_x), 0);
        chk({tag, "_acc_y"}, 32'(dut.acc_y), 0);
    endtask

    initial begin
        int ex_x [4];
        int ex_dx [4];
        ex_x  = '{0, 0, 1, 1};
        ex_dx = '{0, 9, 2, 11};

        steps(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        steps(2);
        chk("idle_no_vs_state", 32'(dut.state), 0);
        chk("idle_no_vs_req", 32'(line_req), 0);

        // Frame start and two preload fetches
        vga_vs = 1'b1;
        step();
        vga_vs = 1'b0;
        chk("vs_gap_req", 32'(line_req), 0);
        step();
        chk("pre0_req", 32'(line_req), 1);
        chk("pre0_row", 32'(line_row), 0);
        line_ack = 1'b1;
        step();
        line_ack = 1'b0;
        chk("pre0_ack_drop", 32'(line_req), 0);
        step();
        chk("pre1_req", 32'(line_req), 1);
        chk("pre1_row", 32'(line_row), 1);
        line_ack = 1'b1;
        step();
        line_ack = 1'b0;
        chk("pre1_ack_drop", 32'(line_req), 0);
        chk("run_state", 32'(dut.state), 3);

        // Line 0: full width
        run_line(1280);
        chk("l0_count", 32'(cap_n), 1280);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("l0_p%0d_x", i), 32'(cx[i]), 32'(ex_x[i]));
            chk($sformatf("l0_p%0d_dx", i), 32'(cdx[i]), 32'(ex_dx[i]));
            chk($sformatf("l0_p%0d_dxy", i), 32'(cdxy[i]), 0);
        end
        chk("l0_last_x", 32'(cx[1279]), 719);
        chk("l0_last_dx_clamp", 32'(cdx[1279]), 0);
        end_line();
        step();
        chk("l0_end_no_req", 32'(line_req), 0);

        // Line 1: dy = 9
        run_line(4);
        chk("l1_p3_dy", 32'(cdy[3]), 9);
        chk("l1_p3_dxy", 32'(cdxy[3]), 99);
        end_line();
        chk("l1_end_req", 32'(line_req), 1);
        chk("l1_end_row", 32'(line_row), 2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("hold%0d_req", i), 32'(line_req), 1);
            chk($sformatf("hold%0d_row", i), 32'(line_row), 2);
        end
        line_ack = 1'b1;
        step();
        line_ack = 1'b0;
        chk("req_ack_drop", 32'(line_req), 0);

        // Line 2 (no fetch at its end), line 3 (dy = 11)
        run_line(4);
        end_line();
        step();
        chk("l2_end_no_req", 32'(line_req), 0);
        run_line(4);
        chk("l3_p3_y", 32'(cy[3]), 1);
        chk("l3_p3_dy", 32'(cdy[3]), 11);
        chk("l3_p3_dxy", 32'(cdxy[3]), 121);
        end_line();
        chk("l3_end_req", 32'(line_req), 1);
        chk("l3_end_row", 32'(line_row), 3);

        // Pixel while a fetch is outstanding
        vga_de = 1'b1;
        step();
        vga_de = 1'b0;
        chk("underflow_set", 32'(err_underflow), 1);
        steps(4);
        chk("underflow_sticky", 32'(err_underflow), 1);
        line_ack = 1'b1;
        step();
        line_ack = 1'b0;
        chk("l3_ack_drop", 32'(line_req), 0);
        chk("underflow_after_ack", 32'(err_underflow), 1);

        // Advance to line 958 with every fetch acked immediately
        line_ack = 1'b1;
        repeat (954) begin
            end_line();
            steps(2);
        end
        line_ack = 1'b0;
        chk("l958_state", 32'(dut.state), 3);
        end_line();
        chk("l959_no_req_a", 32'(line_req), 0);
        step();
        chk("l959_no_req_b", 32'(line_req), 0);
        chk("l959_state", 32'(dut.state), 3);
        run_line(2);
        chk("l959_y", 32'(cy[0]), 539);
        chk("l959_dy_clamp", 32'(cdy[0]), 0);
        chk("l959_p1_dx", 32'(cdx[1]), 9);
        chk("l959_p1_dxy", 32'(cdxy[1]), 0);
        chk("underflow_frame_end", 32'(err_underflow), 1);

        // New frame, then vs arriving mid-request
        vga_vs = 1'b1;
        step();
        vga_vs = 1'b0;
        chk("underflow_clr_vs", 32'(err_underflow), 0);
        step();
        line_ack = 1'b1;
        step();
        line_ack = 1'b0;
        step();
        line_ack = 1'b1;
        step();
        line_ack = 1'b0;
        end_line();
        end_line();
        chk("f2_req", 32'(line_req), 1);
        chk("f2_row", 32'(line_row), 2);
        vga_vs = 1'b1;
        step();
        vga_vs = 1'b0;
        chk("vs_mid_req_gap", 32'(line_req), 0);
        step();
        chk("vs_mid_req_req", 32'(line_req), 1);
        chk("vs_mid_req_row", 32'(line_row), 0);

        // Asynchronous reset with pixels in flight and a request pending
        vga_de = 1'b1;
        steps(2);
        vga_de = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        steps(3);
        chk("post_reset_state", 32'(dut.state), 0);
        chk("post_reset_req", 32'(line_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
